switch_port_ingress: RTL

SWITCH_PORT_INGRESS -- requirements
Module: switch_port_ingress

---
 rtl/switch_port_ingress.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/switch_port_ingress.sv
// ----------------------------------------------------------------------------
// switch_port_ingress
//
// Ingress stage of one switch port. Packets arriving on the port interface are
// screened for legality and queued in a small first-word-fall-through FIFO.
// The switch core drains that FIFO with a valid/ready handshake. Illegal
// packets are rejected, and so are legal packets that arrive while the queue
// is full. Each rejection produces a one-cycle pulse and bumps a saturating
// drop counter.
//
// A packet is illegal when any of these holds:
//   - its source is not this port,
//   - its target mask is empty,
//   - its target mask includes this port (loopback).
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   PORT_ID  one-hot ID of the port served by this block
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   valid_in    one packet per cycle in which it is high
//   source_in   packet source mask
//   target_in   packet target mask (multi-hot allowed)
//   data_in     packet payload
//   pkt_valid   head packet available to the switch core
//   pkt_ready   switch core takes the head packet this cycle
//   pkt_source  head packet source (0 while pkt_valid is low)
//   pkt_target  head packet target (0 while pkt_valid is low)
//   pkt_data    head packet payload (0 while pkt_valid is low)
//   fifo_count  number of packets currently queued
//   full        queue holds DEPTH packets
//   drop_pulse  high for one cycle after each dropped packet
//   drop_count  saturating count of dropped packets
// ----------------------------------------------------------------------------
module switch_port_ingress #(
   parameter int         DEPTH   = 4,
   parameter logic [3:0] PORT_ID = 4'b0001
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid_in,
   input  logic [3:0]                 source_in,
   input  logic [3:0]                 target_in,
   input  logic [7:0]                 data_in,
   output logic                       pkt_valid,
   input  logic                       pkt_ready,
   output logic [3:0]                 pkt_source,
   output logic [3:0]                 pkt_target,
   output logic [7:0]                 pkt_data,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       full,
   output logic                       drop_pulse,
   output logic [7:0]                 drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [3:0]       mem_source [DEPTH];
   logic [3:0]       mem_target [DEPTH];
   logic [7:0]       mem_data   [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             is_legal;
   logic             pop;
   logic             push;
   logic             drop;

   // Classification and handshake decisions for the current edge. A full
   // queue can still take a legal packet when the head leaves at the same
   // edge, because the freed slot is reused immediately.
   always_comb begin
      is_legal = (source_in == PORT_ID) &&
                 (target_in != 4'b0000) &&
                 ((target_in & PORT_ID) == 4'b0000);
      pop      = pkt_valid && pkt_ready;
      push     = valid_in && is_legal && ((count != FULL_COUNT) || pop);
      drop     = valid_in && (!is_legal || ((count == FULL_COUNT) && !pop));
   end

   // Packet storage. It is left unreset on purpose: the head is only visible
   // while the occupancy is nonzero, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_source[wr_ptr] <= source_in;
         mem_target[wr_ptr] <= target_in;
         mem_data[wr_ptr]   <= data_in;
      end
   end

   // Read/write pointers and occupancy. DEPTH is a power of two, so the
   // pointers wrap naturally at their bit width. Reset empties the queue,
   // which discards any packets still held in storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Drop reporting. The pulse follows the edge of the drop by one cycle. The
   // counter stops at 255 rather than wrapping so a flood stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_pulse <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         drop_pulse <= drop;
         if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

   // Head presentation. The fields come straight out of storage, so a packet
   // pushed into an empty queue is visible right after the pushing edge. They
   // are forced to zero when nothing is queued. Because they derive from the
   // reset occupancy, they also clear asynchronously.
   always_comb begin
      pkt_valid  = (count != '0);
      full       = (count == FULL_COUNT);
      fifo_count = count;
      pkt_source = 4'b0000;
      pkt_target = 4'b0000;
      pkt_data   = 8'h00;
      if (pkt_valid) begin
         pkt_source = mem_source[rd_ptr];
         pkt_target = mem_target[rd_ptr];
         pkt_data   = mem_data[rd_ptr];
      end
   end

endmodule
